// File: rtl/pcie_tx_cpld_gen_pkg.sv
// Shared TLP definitions for the completion builder: fmt/type and completion
// status codes, 3DW header field positions, FSM state encodings and helpers
// that pack the three header DWs.
package pcie_tx_cpld_gen_pkg;

  // Fmt codes for 3DW headers
  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;

  // Completion type code, shared by Cpl and CplD
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  localparam logic [7:0] FMT_TYPE_CPL  = {FMT_3DW_NODATA, TYPE_CPL};
  localparam logic [7:0] FMT_TYPE_CPLD = {FMT_3DW_DATA, TYPE_CPL};

  // Completion status codes
  localparam logic [2:0] CPL_STS_SC = 3'b000;
  localparam logic [2:0] CPL_STS_UR = 3'b001;
  localparam logic [2:0] CPL_STS_CA = 3'b100;

  // DW0 field positions
  localparam int DW0_FMT_TYPE_LSB = 24;
  localparam int DW0_TC_LSB       = 20;
  localparam int DW0_ATTR2_BIT    = 18;
  localparam int DW0_ATTR10_LSB   = 12;
  localparam int DW0_AT_LSB       = 10;
  localparam int DW0_LEN_LSB      = 0;

  // DW1 field positions
  localparam int DW1_CPL_ID_LSB = 16;
  localparam int DW1_STS_LSB    = 13;
  localparam int DW1_BCM_BIT    = 12;
  localparam int DW1_BC_LSB     = 0;

  // DW2 field positions
  localparam int DW2_REQ_ID_LSB = 16;
  localparam int DW2_TAG_LSB    = 8;
  localparam int DW2_LADDR_LSB  = 0;

  // FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  // Length field is tx_cpld_len[12:2]; index 10 here is len[12].
  function automatic logic len_is_err(input logic [10:0] len);
    logic [9:0] ndw;
    ndw = len[9:0];
    return len[10] | ~((ndw == 10'd1) | (ndw == 10'd2));
  endfunction

  function automatic logic [31:0] cpl_dw0(input logic [7:0] fmt_type,
                                          input logic [2:0] tc,
                                          input logic [2:0] attr,
                                          input logic [1:0] at,
                                          input logic [9:0] len);
    logic [31:0] dw;
    dw                             = '0;
    dw[DW0_FMT_TYPE_LSB +: 8]      = fmt_type;
    dw[DW0_TC_LSB +: 3]            = tc;
    dw[DW0_ATTR2_BIT]              = attr[2];
    dw[DW0_ATTR10_LSB +: 2]        = attr[1:0];
    dw[DW0_AT_LSB +: 2]            = at;
    dw[DW0_LEN_LSB +: 10]          = len;
    return dw;
  endfunction

  function automatic logic [31:0] cpl_dw1(input logic [15:0] cpl_id,
                                          input logic [2:0]  status,
                                          input logic [11:0] byte_cnt);
    logic [31:0] dw;
    dw                      = '0;
    dw[DW1_CPL_ID_LSB +: 16] = cpl_id;
    dw[DW1_STS_LSB +: 3]     = status;
    dw[DW1_BCM_BIT]          = 1'b0;
    dw[DW1_BC_LSB +: 12]     = byte_cnt;
    return dw;
  endfunction

  function automatic logic [31:0] cpl_dw2(input logic [15:0] req_id,
                                          input logic [7:0]  tag,
                                          input logic [6:0]  lower_addr);
    logic [31:0] dw;
    dw                       = '0;
    dw[DW2_REQ_ID_LSB +: 16] = req_id;
    dw[DW2_TAG_LSB +: 8]     = tag;
    dw[DW2_LADDR_LSB +: 7]   = lower_addr;
    return dw;
  endfunction

endpackage

// File: rtl/pcie_cpld_bytecnt.sv
// Completion byte count and lower address from the request byte enables.
// Single-DW reads use the first-BE table; two-DW reads span from the lowest
// enabled byte of the first DW to the highest enabled byte of the last DW.
module pcie_cpld_bytecnt (
  input  logic        two_dw,
  input  logic [3:0]  first_be,
  input  logic [3:0]  last_be,
  input  logic [6:0]  laddr,
  output logic [11:0] byte_cnt,
  output logic [6:0]  lower_addr
);

  logic [1:0]  first_lo;
  logic [1:0]  last_hi;
  logic [11:0] bc_one;

  // Offset of the lowest enabled byte in the first DW (no enables -> 0)
  always_comb begin
    first_lo = 2'd0;
    casez (first_be)
      4'b???1: first_lo = 2'd0;
      4'b??10: first_lo = 2'd1;
      4'b?100: first_lo = 2'd2;
      4'b1000: first_lo = 2'd3;
      default: first_lo = 2'd0;
    endcase
  end

  // Index of the highest enabled byte in the last DW (no enables -> 0)
  always_comb begin
    last_hi = 2'd0;
    casez (last_be)
      4'b1???: last_hi = 2'd3;
      4'b01??: last_hi = 2'd2;
      4'b001?: last_hi = 2'd1;
      default: last_hi = 2'd0;
    endcase
  end

  // Single-DW byte count table
  always_comb begin
    bc_one = 12'd1;
    casez (first_be)
      4'b1??1:                   bc_one = 12'd4;
      4'b01?1, 4'b1?10:          bc_one = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc_one = 12'd2;
      default:                   bc_one = 12'd1;
    endcase
  end

  // Select the count for the request size; 4 + (hi + 1) - lo for two DWs
  always_comb begin
    byte_cnt = bc_one;
    if (two_dw) begin
      byte_cnt = 12'd5 + {10'd0, last_hi} - {10'd0, first_lo};
    end
  end

  assign lower_addr = {laddr[6:2], first_lo};

endmodule

// File: rtl/pcie_tx_cpld_gen.sv
// Completion TLP generator for BAR register reads. Captures one request in
// IDLE, acknowledges it for a single cycle and streams a 3DW-header CplD (or a
// CA Cpl for unsupported lengths) as 128-bit AXI-stream beats.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no TLP in flight, waiting for tx_cpld_req
// ST_BEAT0 | header + DW0 data (or error Cpl) presented on the stream
// ST_BEAT1 | second data DW of a 2DW completion presented on the stream
module pcie_tx_cpld_gen
  import pcie_tx_cpld_gen_pkg::*;
#(
  parameter int C_PCIE_DATA_WIDTH = 128
) (
  input  logic                           pcie_user_clk,
  input  logic                           pcie_user_rst_n,
  input  logic [15:0]                    completer_id,
  input  logic                           tx_cpld_req,
  input  logic [7:0]                     tx_cpld_tag,
  input  logic [15:0]                    tx_cpld_req_id,
  input  logic [12:2]                    tx_cpld_len,
  input  logic [6:0]                     tx_cpld_laddr,
  input  logic [63:0]                    tx_cpld_data,
  input  logic [2:0]                     tx_cpld_tc,
  input  logic [2:0]                     tx_cpld_attr,
  input  logic [1:0]                     tx_cpld_at,
  input  logic [7:0]                     tx_cpld_be,
  output logic                           tx_cpld_req_ack,
  output logic [C_PCIE_DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [C_PCIE_DATA_WIDTH/8-1:0] tx_axis_tkeep,
  output logic                           tx_axis_tlast,
  output logic                           tx_axis_tvalid,
  input  logic                           tx_axis_tready,
  output logic                           cpld_len_err,
  output logic [15:0]                    cpld_cnt
);

  localparam int KW = C_PCIE_DATA_WIDTH / 8;

  logic [1:0]                   state_q, state_d;
  logic                         ack_q, ack_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;
  logic [KW-1:0]                tkeep_q, tkeep_d;
  logic [C_PCIE_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [31:0]                  data_hi_q, data_hi_d;
  logic                         len_err_q, len_err_d;
  logic [15:0]                  cnt_q, cnt_d;

  logic [9:0]                   req_ndw;
  logic                         req_err;
  logic                         req_two;
  logic [11:0]                  req_bc;
  logic [6:0]                   req_la;
  logic [31:0]                  hdr_dw0;
  logic [31:0]                  hdr_dw1;
  logic [31:0]                  hdr_dw2;
  logic [C_PCIE_DATA_WIDTH-1:0] beat0;
  logic                         handshake;

  assign req_ndw = tx_cpld_len[11:2];
  assign req_err = len_is_err(tx_cpld_len);
  assign req_two = ~req_err & (req_ndw == 10'd2);

  // Error completions reuse the single-DW byte count derived from first BE.
  pcie_cpld_bytecnt u_bytecnt (
    .two_dw     (req_two),
    .first_be   (tx_cpld_be[3:0]),
    .last_be    (tx_cpld_be[7:4]),
    .laddr      (tx_cpld_laddr),
    .byte_cnt   (req_bc),
    .lower_addr (req_la)
  );

  // Header DWs are built straight from the live request so that the first
  // beat can be registered on the capture edge.
  always_comb begin
    hdr_dw0 = cpl_dw0(req_err ? FMT_TYPE_CPL : FMT_TYPE_CPLD,
                      tx_cpld_tc, tx_cpld_attr, tx_cpld_at,
                      req_err ? 10'd0 : req_ndw);
    hdr_dw1 = cpl_dw1(completer_id, req_err ? CPL_STS_CA : CPL_STS_SC, req_bc);
    hdr_dw2 = cpl_dw2(tx_cpld_req_id, tx_cpld_tag, req_la);
    beat0   = {(req_err ? 32'h0 : tx_cpld_data[31:0]), hdr_dw2, hdr_dw1, hdr_dw0};
  end

  assign handshake = tvalid_q & tx_axis_tready;

  // Capture, beat sequencing and TLP accounting
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tkeep_d   = tkeep_q;
    tdata_d   = tdata_q;
    data_hi_d = data_hi_q;
    len_err_d = len_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_cpld_req) begin
          ack_d     = 1'b1;
          tvalid_d  = 1'b1;
          tdata_d   = beat0;
          tkeep_d   = req_err ? 16'h0FFF : 16'hFFFF;
          tlast_d   = ~req_two;
          data_hi_d = tx_cpld_data[63:32];
          if (req_err) begin
            len_err_d = 1'b1;
          end
          state_d   = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (handshake) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tkeep_d  = '0;
            tdata_d  = '0;
            cnt_d    = cnt_q + 16'd1;
            state_d  = ST_IDLE;
          end else begin
            tdata_d  = {96'h0, data_hi_q};
            tkeep_d  = 16'h000F;
            tlast_d  = 1'b1;
            state_d  = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tkeep_d  = '0;
          tdata_d  = '0;
          cnt_d    = cnt_q + 16'd1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tkeep_d  = '0;
        tdata_d  = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any TLP in flight
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tkeep_q   <= '0;
      tdata_q   <= '0;
      data_hi_q <= '0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tkeep_q   <= tkeep_d;
      tdata_q   <= tdata_d;
      data_hi_q <= data_hi_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_cpld_req_ack = ack_q;
  assign tx_axis_tvalid  = tvalid_q;
  assign tx_axis_tlast   = tlast_q;
  assign tx_axis_tkeep   = tkeep_q;
  assign tx_axis_tdata   = tdata_q;
  assign cpld_len_err    = len_err_q;
  assign cpld_cnt        = cnt_q;

endmodule

// File: tb/tb_pcie_tx_cpld_gen.sv
// Bench for the completion TLP generator: requests push expected beats into a
// scoreboard queue, a negedge monitor pops and compares on every handshake and
// checks that stalled beats hold steady.
module tb_pcie_tx_cpld_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  completer_id = '0;
  logic         req = 1'b0;
  logic [7:0]   tag = '0;
  logic [15:0]  req_id = '0;
  logic [12:2]  len = '0;
  logic [6:0]   laddr = '0;
  logic [63:0]  data = '0;
  logic [2:0]   tc = '0;
  logic [2:0]   attr = '0;
  logic [1:0]   at = '0;
  logic [7:0]   be = '0;
  logic         ack;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready = 1'b0;
  logic         len_err;
  logic [15:0]  cnt;

  always #5 clk = ~clk;

  pcie_tx_cpld_gen #(.C_PCIE_DATA_WIDTH(128)) dut (
    .pcie_user_clk   (clk),
    .pcie_user_rst_n (rst_n),
    .completer_id    (completer_id),
    .tx_cpld_req     (req),
    .tx_cpld_tag     (tag),
    .tx_cpld_req_id  (req_id),
    .tx_cpld_len     (len),
    .tx_cpld_laddr   (laddr),
    .tx_cpld_data    (data),
    .tx_cpld_tc      (tc),
    .tx_cpld_attr    (attr),
    .tx_cpld_at      (at),
    .tx_cpld_be      (be),
    .tx_cpld_req_ack (ack),
    .tx_axis_tdata   (tdata),
    .tx_axis_tkeep   (tkeep),
    .tx_axis_tlast   (tlast),
    .tx_axis_tvalid  (tvalid),
    .tx_axis_tready  (tready),
    .cpld_len_err    (len_err),
    .cpld_cnt        (cnt)
  );

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [10:0] len;
    logic [6:0]  laddr;
    logic [63:0] data;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [1:0]  at;
    logic [7:0]  be;
    logic [15:0] cid;
  } req_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_cnt = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  // Sink ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  // Scoreboard monitor: compare each handshaken beat, check stalled beats hold
  beat_t held;
  logic  held_v = 1'b0;
  beat_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== held.data || tkeep !== held.keep || tlast !== held.last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, need v=1 d=%h k=%h l=%b",
                   tvalid, tdata, tkeep, tlast, held.data, held.keep, held.last);
        end
      end
      held_v = 1'b0;
      if (tvalid === 1'b1) begin
        if (tready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got d=%h k=%h l=%b, need no beat", tdata, tkeep, tlast);
          end else begin
            mon_e = exp_q.pop_front();
            if (tdata !== mon_e.data || tkeep !== mon_e.keep || tlast !== mon_e.last) begin
              errors++;
              $display("FAIL beat: got d=%h k=%h l=%b, need d=%h k=%h l=%b",
                       tdata, tkeep, tlast, mon_e.data, mon_e.keep, mon_e.last);
            end
            if (mon_e.last) exp_cnt++;
          end
        end else begin
          held_v    = 1'b1;
          held.data = tdata;
          held.keep = tkeep;
          held.last = tlast;
        end
      end
    end
  end

  function automatic req_t mk(input logic [7:0] t, input logic [15:0] rid,
                              input logic [10:0] l, input logic [6:0] la,
                              input logic [63:0] d, input logic [2:0] c,
                              input logic [2:0] a, input logic [1:0] s,
                              input logic [7:0] b, input logic [15:0] cid);
    req_t r;
    r.tag = t; r.rid = rid; r.len = l; r.laddr = la; r.data = d;
    r.tc = c; r.attr = a; r.at = s; r.be = b; r.cid = cid;
    return r;
  endfunction

  // Reference completion model
  function automatic void push_expected(input req_t r);
    logic [9:0]  ndw;
    logic        err;
    int          lo, hi_first, hi_last;
    logic [11:0] bc;
    logic [31:0] dw0, dw1, dw2;
    beat_t       b;
    ndw = r.len[9:0];
    err = r.len[10] || !(ndw == 10'd1 || ndw == 10'd2);
    lo = 0; hi_first = 0; hi_last = 0;
    for (int i = 3; i >= 0; i--) if (r.be[i]) lo = i;
    for (int i = 0; i < 4; i++) if (r.be[i]) hi_first = i;
    for (int i = 0; i < 4; i++) if (r.be[4+i]) hi_last = i;
    if (err || ndw == 10'd1)
      bc = (r.be[3:0] == 4'h0) ? 12'd1 : 12'(hi_first - lo + 1);
    else
      bc = 12'(4 + hi_last + 1 - lo);
    dw0 = {(err ? 3'b000 : 3'b010), 5'b01010, 1'b0, r.tc, 1'b0, r.attr[2], 4'b0,
           r.attr[1:0], r.at, (err ? 10'd0 : ndw)};
    dw1 = {r.cid, (err ? 3'b100 : 3'b000), 1'b0, bc};
    dw2 = {r.rid, r.tag, 1'b0, r.laddr[6:2], 2'(lo)};
    b.data = {(err ? 32'h0 : r.data[31:0]), dw2, dw1, dw0};
    b.keep = err ? 16'h0FFF : 16'hFFFF;
    b.last = err || (ndw == 10'd1);
    exp_q.push_back(b);
    if (!err && ndw == 10'd2) begin
      b.data = {96'h0, r.data[63:32]};
      b.keep = 16'h000F;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive(input req_t r);
    tag = r.tag; req_id = r.rid; len = r.len; laddr = r.laddr; data = r.data;
    tc = r.tc; attr = r.attr; at = r.at; be = r.be; completer_id = r.cid;
  endtask

  // Raise req, check ack/tvalid at N+1, drop req after ack, check ack pulse
  task automatic send_req(input req_t r, input string name);
    @(posedge clk); #2;
    drive(r);
    req = 1'b1;
    push_expected(r);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got ack=%b tvalid=%b, need 1 1", name, ack, tvalid);
    end
    @(posedge clk); #2;
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_pulse: got ack=%b, need 0", name, ack);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s drain: got %0d beats pending, need 0", name, exp_q.size());
    end
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s cpld_cnt: got %0d, need %0d", name, cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== 16'h0 ||
        tdata !== 128'h0 || len_err !== 1'b0 || cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got ack=%b v=%b l=%b k=%h d=%h err=%b cnt=%0d, need all 0",
               ack, tvalid, tlast, tkeep, tdata, len_err, cnt);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_dw();
    req_t r;
    r = mk(8'h21, 16'h0100, 11'd1, 7'h14, 64'h0000_0000_1234_5678, 3'd0, 3'd0, 2'd0,
           8'h0F, 16'h0300);
    ready_mode = 2;
    send_req(r, "single_dw");
    checks++;
    if (tdata !== {32'h1234_5678, 32'h0100_2114, 32'h0300_0004, 32'h4A00_0001} ||
        tkeep !== 16'hFFFF || tlast !== 1'b1) begin
      errors++;
      $display("FAIL single_dw_beat: got d=%h k=%h l=%b, need d=123456780100211403000004%s k=ffff l=1",
               tdata, tkeep, tlast, "4a000001");
    end
    ready_mode = 0;
    wait_drain("single_dw");
  endtask

  task automatic test_two_dw();
    req_t r;
    int   cnt0;
    wait_drain("two_dw_pre");
    cnt0 = int'(cnt);
    r = mk(8'h5A, 16'h0A0B, 11'd2, 7'h30, 64'hA5A5_0001_DEAD_BEEF, 3'd5, 3'd4, 2'd2,
           8'hFF, 16'h0300);
    ready_mode = 2;
    send_req(r, "two_dw");
    checks++;
    if (tdata[9:0] !== 10'd2 || tdata[43:32] !== 12'd8 || tdata[70:64] !== 7'h30 || tlast !== 1'b0) begin
      errors++;
      $display("FAIL two_dw_hdr: got len=%0d bc=%0d la=%h l=%b, need 2 8 30 0",
               tdata[9:0], tdata[43:32], tdata[70:64], tlast);
    end
    ready_mode = 0;
    wait_drain("two_dw");
    checks++;
    if (int'(cnt) !== cnt0 + 1) begin
      errors++;
      $display("FAIL two_dw_cnt: got %0d, need %0d", cnt, cnt0 + 1);
    end
  endtask

  task automatic test_byte_enables();
    logic [3:0] fbe [9];
    req_t r;
    fbe = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h5, 4'hA, 4'h9, 4'h0};
    r = mk(8'h33, 16'h1234, 11'd1, 7'h2B, 64'h0000_0000_CAFE_F00D, 3'd0, 3'd0, 2'd0,
           8'h0C, 16'h0300);
    ready_mode = 2;
    send_req(r, "be_0c");
    checks++;
    if (tdata[43:32] !== 12'd2 || tdata[70:64] !== 7'h2A) begin
      errors++;
      $display("FAIL be_0c: got bc=%0d la=%h, need 2 2a", tdata[43:32], tdata[70:64]);
    end
    ready_mode = 0;
    wait_drain("be_0c");
    for (int i = 0; i < 9; i++) begin
      r = mk(8'(i + 1), 16'hBEEF, 11'd1, 7'(i * 13 + 3), {32'h0, 32'(i) * 32'h0101_0101},
             3'(i), 3'(i + 1), 2'(i), {4'h0, fbe[i]}, 16'h0300);
      send_req(r, "be_table");
      wait_drain("be_table");
    end
    r = mk(8'h44, 16'h0001, 11'd2, 7'h40, 64'h1111_2222_3333_4444, 3'd1, 3'd2, 2'd1,
           8'h1E, 16'h0700);
    send_req(r, "be_1e");
    wait_drain("be_1e");
    r = mk(8'h45, 16'h0002, 11'd2, 7'h7F, 64'h5555_6666_7777_8888, 3'd7, 3'd7, 2'd3,
           8'h3C, 16'h0700);
    send_req(r, "be_3c");
    wait_drain("be_3c");
  endtask

  task automatic test_len_err();
    req_t r;
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_pre: got %b, need 0", len_err);
    end
    r = mk(8'h77, 16'h0200, 11'd4, 7'h10, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd0, 2'd0,
           8'hFF, 16'h0300);
    ready_mode = 2;
    send_req(r, "len4");
    checks++;
    if (tdata[31:0] !== 32'h0A00_0000 || tdata[47:45] !== 3'b100 || tkeep !== 16'h0FFF || tlast !== 1'b1) begin
      errors++;
      $display("FAIL len4_cpl: got dw0=%h sts=%b k=%h l=%b, need 0a000000 100 0fff 1",
               tdata[31:0], tdata[47:45], tkeep, tlast);
    end
    ready_mode = 0;
    wait_drain("len4");
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_set: got %b, need 1", len_err);
    end
    r = mk(8'h78, 16'h0200, 11'h401, 7'h04, 64'h0, 3'd2, 3'd1, 2'd1, 8'h03, 16'h0300);
    send_req(r, "len12");
    wait_drain("len12");
    r = mk(8'h79, 16'h0200, 11'd1, 7'h08, 64'h0000_0000_0BAD_F00D, 3'd0, 3'd0, 2'd0,
           8'h0F, 16'h0300);
    send_req(r, "after_err");
    wait_drain("after_err");
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_sticky: got %b, need 1", len_err);
    end
  endtask

  task automatic test_stall();
    req_t r;
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      r = mk(8'(8'h80 + i), 16'h0F00, 11'd2, 7'(i * 8), {32'($urandom), 32'($urandom)},
             3'(i), 3'd0, 2'd0, 8'hF7, 16'h0300);
      send_req(r, "stall");
      wait_drain("stall");
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    req_t r;
    int   acks, last_c;
    wait_drain("b2b_pre");
    r = mk(8'h99, 16'h0404, 11'd1, 7'h0C, 64'h0000_0000_ABCD_0123, 3'd0, 3'd0, 2'd0,
           8'h0F, 16'h0300);
    @(posedge clk); #2;
    drive(r);
    req = 1'b1;
    for (int k = 0; k < 3; k++) push_expected(r);
    acks = 0;
    last_c = 0;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        if (acks > 0) begin
          checks++;
          if (c - last_c != 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, need 2", c - last_c);
          end
        end
        last_c = c;
        acks++;
      end
    end
    @(posedge clk); #2;
    req = 1'b0;
    checks++;
    if (acks != 3) begin
      errors++;
      $display("FAIL b2b_acks: got %0d, need 3", acks);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    req_t r;
    ready_mode = 0;
    wait_drain("rst_mid_pre");
    r = mk(8'hC1, 16'h0808, 11'd2, 7'h20, 64'h0123_4567_89AB_CDEF, 3'd0, 3'd0, 2'd0,
           8'hFF, 16'h0300);
    @(posedge clk); #2;
    drive(r);
    req = 1'b1;
    push_expected(r);
    @(posedge clk); #2;
    req = 1'b0;
    #1;
    ready_mode = 2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b1 || tkeep !== 16'h000F || tlast !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_beat1: got v=%b k=%h l=%b, need 1 000f 1", tvalid, tkeep, tlast);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tkeep !== 16'h0 || tdata !== 128'h0 ||
        ack !== 1'b0 || cnt !== 16'h0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b l=%b k=%h d=%h ack=%b cnt=%0d err=%b, need all 0",
               tvalid, tlast, tkeep, tdata, ack, cnt, len_err);
    end
    exp_q.delete();
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 0;
    r = mk(8'hC2, 16'h0808, 11'd1, 7'h24, 64'h0000_0000_5A5A_A5A5, 3'd1, 3'd0, 2'd0,
           8'h0F, 16'h0300);
    send_req(r, "after_rst");
    wait_drain("after_rst");
    checks++;
    if (cnt !== 16'd1) begin
      errors++;
      $display("FAIL after_rst_cnt: got %0d, need 1", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_dw();
    test_two_dw();
    test_byte_enables();
    test_len_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
